control_sequencer: RTL and testbench



---
 rtl/sap_ctrl_pkg.sv | 35 +++
 rtl/control_sequencer_ring_counter.sv | 20 ++
 rtl/control_sequencer.sv | 97 +++++++++
 tb/tb_control_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the SAP controller-sequencer: opcodes, one-hot
// T-state encodings and the packed control word.
package sap_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct packed {
        logic pc_inc;
        logic pc_en;
        logic mar_ld;
        logic ram_en;
        logic ir_ld;
        logic ir_en;
        logic a_ld;
        logic a_en;
        logic b_ld;
        logic alu_en;
        logic alu_sub;
        logic out_ld;
    } ctrl_word_t;

    localparam ctrl_word_t CW_IDLE = '0;

endpackage

// File: rtl/control_sequencer_ring_counter.sv
// Six-state one-hot ring counter with enable and synchronous active-low clear.
module ring_counter
    import sap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clear_n,
    input  logic       en,
    output logic [5:0] t_state
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (!clear_n)
            t_state <= T1;
        else if (en)
            t_state <= {t_state[4:0], t_state[5]};
    end

endmodule

// File: rtl/control_sequencer.sv
// Controller-sequencer: T-state ring, sticky halt and microcode decode
// driving every datapath bus-enable and load strobe.
module control_sequencer
    import sap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clear_n,
    input  logic [3:0] opcode,
    input  logic       run,
    input  logic       step,
    output logic       pc_inc,
    output logic       pc_en,
    output logic       mar_ld,
    output logic       ram_en,
    output logic       ir_ld,
    output logic       ir_en,
    output logic       a_ld,
    output logic       a_en,
    output logic       b_ld,
    output logic       alu_en,
    output logic       alu_sub,
    output logic       out_ld,
    output logic [5:0] t_state,
    output logic       halted
);

    logic       adv;
    logic       hlt_at_t4;
    ctrl_word_t cw;

    assign adv       = !halted && (run || step);
    assign hlt_at_t4 = (t_state == T4) && (opcode == OP_HLT);

    // HLT parks the ring at T4 on the same edge that sets the halt flag.
    ring_counter u_ring (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (adv && !hlt_at_t4),
        .t_state (t_state)
    );

    always_ff @(posedge clk) begin
        if (!clear_n)
            halted <= 1'b0;
        else if (adv && hlt_at_t4)
            halted <= 1'b1;
    end

    // NOTE: cw gets a full default before the case so no latch is inferred
    // for strobes an arm leaves untouched.
    always_comb begin
        cw = CW_IDLE;
        if (clear_n && adv) begin
            case (t_state)
                T1: begin cw.pc_en = 1'b1; cw.mar_ld = 1'b1; end
                T2: cw.pc_inc = 1'b1;
                T3: begin cw.ram_en = 1'b1; cw.ir_ld = 1'b1; end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin cw.ir_en = 1'b1; cw.mar_ld = 1'b1; end
                        OP_OUT:                 begin cw.a_en = 1'b1; cw.out_ld = 1'b1; end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         begin cw.ram_en = 1'b1; cw.a_ld = 1'b1; end
                        OP_ADD, OP_SUB: begin cw.ram_en = 1'b1; cw.b_ld = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        cw.alu_en  = 1'b1;
                        cw.a_ld    = 1'b1;
                        cw.alu_sub = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_inc  = cw.pc_inc;
    assign pc_en   = cw.pc_en;
    assign mar_ld  = cw.mar_ld;
    assign ram_en  = cw.ram_en;
    assign ir_ld   = cw.ir_ld;
    assign ir_en   = cw.ir_en;
    assign a_ld    = cw.a_ld;
    assign a_en    = cw.a_en;
    assign b_ld    = cw.b_ld;
    assign alu_en  = cw.alu_en;
    assign alu_sub = cw.alu_sub;
    assign out_ld  = cw.out_ld;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a T-state-number reference model
// queues the expected response of every cycle and a negedge monitor checks it.
module tb_control_sequencer;

    localparam int B_PC_INC  = 11;
    localparam int B_PC_EN   = 10;
    localparam int B_MAR_LD  = 9;
    localparam int B_RAM_EN  = 8;
    localparam int B_IR_LD   = 7;
    localparam int B_IR_EN   = 6;
    localparam int B_A_LD    = 5;
    localparam int B_A_EN    = 4;
    localparam int B_B_LD    = 3;
    localparam int B_ALU_EN  = 2;
    localparam int B_ALU_SUB = 1;
    localparam int B_OUT_LD  = 0;

    typedef struct {
        logic [11:0] word;
        logic [5:0]  t;
        logic        h;
        int          phase;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear_n, run, step;
    logic [3:0] opcode;
    logic pc_inc, pc_en, mar_ld, ram_en, ir_ld, ir_en;
    logic a_ld, a_en, b_ld, alu_en, alu_sub, out_ld;
    logic [5:0] t_state;
    logic       halted;

    exp_t       sb[$];
    int         vectors    = 0;
    int         miscompares = 0;
    int         phase      = 0;
    int         m_t        = 1;
    bit         m_h        = 1'b0;
    logic [3:0] next_op    = 4'h0;

    control_sequencer dut (
        .clk(clk), .clear_n(clear_n), .opcode(opcode), .run(run), .step(step),
        .pc_inc(pc_inc), .pc_en(pc_en), .mar_ld(mar_ld), .ram_en(ram_en),
        .ir_ld(ir_ld), .ir_en(ir_en), .a_ld(a_ld), .a_en(a_en), .b_ld(b_ld),
        .alu_en(alu_en), .alu_sub(alu_sub), .out_ld(out_ld),
        .t_state(t_state), .halted(halted)
    );

    always #5 clk = ~clk;

    // Strobe table written directly from the microcode listing, indexed by T-number.
    function automatic logic [11:0] spec_word(input int t, input logic [3:0] op);
        logic [11:0] w;
        w = '0;
        case (t)
            1: begin w[B_PC_EN] = 1'b1; w[B_MAR_LD] = 1'b1; end
            2: w[B_PC_INC] = 1'b1;
            3: begin w[B_RAM_EN] = 1'b1; w[B_IR_LD] = 1'b1; end
            4: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                    w[B_IR_EN] = 1'b1; w[B_MAR_LD] = 1'b1;
                end else if (op == 4'hE) begin
                    w[B_A_EN] = 1'b1; w[B_OUT_LD] = 1'b1;
                end
            end
            5: begin
                if (op == 4'h0) begin
                    w[B_RAM_EN] = 1'b1; w[B_A_LD] = 1'b1;
                end else if (op == 4'h1 || op == 4'h2) begin
                    w[B_RAM_EN] = 1'b1; w[B_B_LD] = 1'b1;
                end
            end
            6: begin
                if (op == 4'h1 || op == 4'h2) begin
                    w[B_ALU_EN] = 1'b1; w[B_A_LD] = 1'b1;
                    w[B_ALU_SUB] = (op == 4'h2);
                end
            end
            default: ;
        endcase
        return w;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, queue the expectation, advance the model, wait for the edge.
    task automatic cyc(input logic cn, input logic r, input logic s);
        exp_t e;
        bit   adv;
        if (m_t == 1) opcode = next_op;
        clear_n = cn; run = r; step = s;
        adv     = !m_h && (r || s);
        e.word  = (cn && adv) ? spec_word(m_t, opcode) : 12'h000;
        e.t     = 6'(1 << (m_t - 1));
        e.h     = m_h;
        e.phase = phase;
        sb.push_back(e);
        if (!cn) begin
            m_t = 1; m_h = 1'b0;
        end else if (adv) begin
            if (m_t == 4 && opcode == 4'hF) m_h = 1'b1;
            else                            m_t = (m_t == 6) ? 1 : m_t + 1;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [3:0] rand_op();
        int pick;
        pick = $urandom_range(0, 11);
        case (pick)
            0, 1:    return 4'h0;
            2, 3:    return 4'h1;
            4, 5:    return 4'h2;
            6, 7:    return 4'hE;
            8:       return 4'hF;
            default: return 4'($urandom_range(3, 13));
        endcase
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [11:0] act;
            e   = sb.pop_front();
            act = {pc_inc, pc_en, mar_ld, ram_en, ir_ld, ir_en,
                   a_ld, a_en, b_ld, alu_en, alu_sub, out_ld};
            check($sformatf("strobes phase %0d", e.phase), act, e.word);
            check($sformatf("t_state phase %0d", e.phase), {6'b0, t_state}, {6'b0, e.t});
            check($sformatf("halted phase %0d", e.phase), {11'b0, halted}, {11'b0, e.h});
            check($sformatf("bus_single_driver phase %0d", e.phase),
                  {11'b0, ($countones({pc_en, ram_en, ir_en, a_en, alu_en}) > 1)}, 12'h000);
        end
    end

    initial begin
        clear_n = 1'b0; run = 1'b1; step = 1'b0; opcode = 4'h0;
        @(posedge clk); #1;

        phase = 1;  // reset with run high
        cyc(0, 1, 0); cyc(0, 1, 0);

        phase = 2;  // LDA free-run, two instructions
        next_op = 4'h0;
        repeat (12) cyc(1, 1, 0);

        phase = 3;  // SUB, OUT, ADD, NOP
        next_op = 4'h2; repeat (6) cyc(1, 1, 0);
        next_op = 4'hE; repeat (6) cyc(1, 1, 0);
        next_op = 4'h1; repeat (6) cyc(1, 1, 0);
        next_op = 4'h7; repeat (6) cyc(1, 1, 0);

        phase = 4;  // single-step, pulse every 4th cycle, then step held
        next_op = 4'h1;
        for (int i = 0; i < 48; i++) cyc(1, 0, (i % 4) == 0);
        repeat (9) cyc(1, 0, 1);

        phase = 5;  // step ignored under run, then run drops mid-instruction
        next_op = 4'h2;
        repeat (10) cyc(1, 1, 1'($urandom_range(0, 1)));
        repeat (2) cyc(1, 1, 0);
        repeat (5) cyc(1, 0, 0);
        cyc(1, 0, 1);
        repeat (3) cyc(1, 0, 0);
        repeat (8) cyc(1, 1, 0);

        phase = 6;  // randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            if (m_t == 1) next_op = rand_op();
            cyc(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        phase = 7;  // HLT holds 20+ cycles, then clear restores T1
        cyc(0, 1, 0);
        next_op = 4'hF;
        repeat (4) cyc(1, 1, 0);
        for (int i = 0; i < 21; i++) cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        next_op = 4'h0;
        cyc(0, 1, 1);
        repeat (7) cyc(1, 1, 0);

        phase = 8;  // reset at T5 of ADD with step high
        cyc(0, 1, 0);
        next_op = 4'h1;
        for (int i = 0; i < 12 && m_t != 5; i++) cyc(1, 1, 0);
        cyc(0, 0, 1);
        repeat (3) cyc(1, 0, 0);
        repeat (8) cyc(1, 1, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
